cache_line_mem_master: RTL and testbench
========================================

Name: cache_line_mem_master

Overview:
- Cache-side initiator for the 128-bit line SRAM controller.
- Accepts one miss/flush command from the cache controller. Issues an optional dirty-line writeback, then an optional line refill, as single-cycle read/write strobes on the controller's line interface. Waits for ACK on each, then returns refill data to the cache.
- Holds address and write data stable for the whole transfer, because the controller re-samples them every cycle. Adds a watchdog timeout so a lost ACK cannot hang the pipeline.

Parameters:
- SRAM_AW, 18, SRAM halfword address width driven on o_MEM_ADDR[SRAM_AW-1:0].
- TIMEOUT_CYC, 64, max cycles from strobe to ACK before the transfer is aborted with error.
- CNT_W, 7, width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- i_req_valid  in  1  cache command valid
- o_req_ready  out  1  block idle, can accept a command
- i_req_wb  in  1  perform writeback of i_wb_data to i_wb_addr
- i_req_rf  in  1  perform refill from i_rf_addr
- i_wb_addr  in  32  byte address of victim line
- i_wb_data  in  128  victim line data
- i_rf_addr  in  32  byte address of missing line
- o_resp_valid  out  1  one-cycle completion pulse
- o_resp_data  out  128  refill line, valid with o_resp_valid when refill done
- o_resp_err  out  1  timeout occurred during this command
- o_MEM_ADDR  out  32  line base halfword address to controller
- o_MEM_WDATA  out  128  write line to controller
- o_MEM_WREN  out  1  write strobe (single cycle)
- o_MEM_RDEN  out  1  read strobe (single cycle)
- i_MEM_RDATA  in  128  controller read data
- i_MEM_ACK  in  1  controller transfer complete

Behaviour:
- Reset (asynchronous): state IDLE. All registered outputs 0: o_resp_valid, o_resp_err, o_resp_data, o_MEM_ADDR, o_MEM_WDATA, o_MEM_WREN, o_MEM_RDEN. Counter 0. o_req_ready = 1 after reset.
- Reset mid-transfer: drop everything and return to IDLE. No response is issued for the aborted command.
- Address mapping: o_MEM_ADDR = zero-extended {byte_addr[SRAM_AW+0:4], 3'b000}, i.e. eight halfwords per line. byte_addr[3:0] is ignored. Upper bits beyond SRAM_AW are 0.
- Handshake on cache side: command accepted when i_req_valid & o_req_ready. o_req_ready = (state == IDLE). Addresses and data are captured into registers at acceptance.
- Controller rule: o_MEM_WREN and o_MEM_RDEN are never both high. Each is high exactly one cycle per transfer. o_MEM_ADDR and o_MEM_WDATA are held constant from the strobe cycle through the ACK cycle.
- States:
  - IDLE: on accept, go to WB_REQ if wb=1, else RF_REQ if rf=1, else DONE (no memory traffic).
  - WB_REQ: drive o_MEM_WREN=1 with wb address/data; clear counter; go to WB_WAIT.
  - WB_WAIT: on i_MEM_ACK, go to RF_REQ if rf, else DONE. If counter reaches TIMEOUT_CYC-1 without ACK, set err and go to DONE (refill skipped).
  - RF_REQ: drive o_MEM_RDEN=1 with rf address; clear counter; go to RF_WAIT. The refill strobe is issued no earlier than the cycle after the WB ACK, so the controller sees it from idle.
  - RF_WAIT: on i_MEM_ACK, capture i_MEM_RDATA into o_resp_data and go to DONE. On timeout, set err and go to DONE; o_resp_data keeps its previous value.
  - DONE: o_resp_valid=1 for one cycle, o_resp_err reflects the command; go to IDLE. err is cleared on the next accept.
- Latency:
  - Empty command: resp 2 cycles after accept.
  - Refill only: accept, then RF_REQ next cycle, then wait for ACK, then DONE one cycle after ACK.
- ACK arriving in IDLE/REQ/DONE (spurious) is ignored.
- ACK in the same cycle the timeout fires: ACK wins, no error.

Decomposition:
- Package cache_mem_pkg:
  - typedef enum mem_master_state_e {IDLE, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, DONE}
  - LINE_W=128
  - function line_to_sram_addr(byte_addr)
- Sub-module mem_ack_watchdog: counter with clear, enable, and timeout-flag outputs, parameterised by TIMEOUT_CYC/CNT_W.

Test Plan:
- Refill only, rf_addr=0x0000_0120, controller model ACKs 8 cycles after RDEN with data 0x0123...CDEF -> single RDEN, o_MEM_ADDR=0x90, resp_valid with that data, err=0.
- Writeback+refill, wb_addr=0x40, wb_data=0xAAAA..., rf_addr=0x80 -> WREN @ addr 0x20 with stable WDATA until ACK, then RDEN @ 0x40 at least 1 cycle after the WB ACK, single resp, err=0.
- Neither bit set -> no strobes, resp_valid 2 cycles after accept, err=0.
- No ACK on refill, TIMEOUT_CYC=64 -> resp_valid with err=1 after 64 wait cycles; next command accepted and completes with err=0.
- Writeback times out with rf=1 -> refill skipped, no RDEN, err=1.
- Assert rst_ni low during RF_WAIT, then ACK arrives after release -> no resp, o_req_ready=1, all MEM outputs 0.

Source files
------------

// File: rtl/cache_line_mem_master_pkg.sv
// Shared types and helpers for the cache-side line memory master.
// Maps byte addresses onto the 128-bit line SRAM controller's halfword addressing.
package cache_mem_pkg;

   localparam int LINE_W = 128;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WB_REQ  = 3'd1,
      WB_WAIT = 3'd2,
      RF_REQ  = 3'd3,
      RF_WAIT = 3'd4,
      DONE    = 3'd5
   } mem_master_state_e;

   // A line is eight halfwords, so the line index lands on halfword bit 3 and
   // anything above the SRAM address width is forced to zero.
   function automatic logic [31:0] line_to_sram_addr(input logic [31:0] byte_addr,
                                                     input int unsigned aw);
      logic [31:0] mask;
      mask = (32'h1 << aw) - 32'h1;
      return ((byte_addr >> 4) << 3) & mask;
   endfunction

endpackage

// File: rtl/cache_line_mem_master_if.sv
// Bundles the cache command/response handshake and the line controller bus.
// The master modport is the block's view; slave is the cache/controller side.
interface cache_line_mem_master_if;
   import cache_mem_pkg::*;

   logic              i_req_valid;
   logic              o_req_ready;
   logic              i_req_wb;
   logic              i_req_rf;
   logic [31:0]       i_wb_addr;
   logic [LINE_W-1:0] i_wb_data;
   logic [31:0]       i_rf_addr;
   logic              o_resp_valid;
   logic [LINE_W-1:0] o_resp_data;
   logic              o_resp_err;
   logic [31:0]       o_MEM_ADDR;
   logic [LINE_W-1:0] o_MEM_WDATA;
   logic              o_MEM_WREN;
   logic              o_MEM_RDEN;
   logic [LINE_W-1:0] i_MEM_RDATA;
   logic              i_MEM_ACK;

   modport master (
      input  i_req_valid, i_req_wb, i_req_rf, i_wb_addr, i_wb_data, i_rf_addr,
      input  i_MEM_RDATA, i_MEM_ACK,
      output o_req_ready, o_resp_valid, o_resp_data, o_resp_err,
      output o_MEM_ADDR, o_MEM_WDATA, o_MEM_WREN, o_MEM_RDEN
   );

   modport slave (
      output i_req_valid, i_req_wb, i_req_rf, i_wb_addr, i_wb_data, i_rf_addr,
      output i_MEM_RDATA, i_MEM_ACK,
      input  o_req_ready, o_resp_valid, o_resp_data, o_resp_err,
      input  o_MEM_ADDR, o_MEM_WDATA, o_MEM_WREN, o_MEM_RDEN
   );

endinterface

// File: rtl/cache_line_mem_master_watchdog.sv
// Counts wait cycles after a strobe and flags when the ACK budget is used up.
// The flag is only meaningful while enable_i is high.
module mem_ack_watchdog #(
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 7
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic timeout_o
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             atLast;

   assign atLast    = (cnt_q == LAST_CNT);
   assign timeout_o = enable_i && atLast;

   // Saturate on the last count so a stuck enable cannot wrap into a fresh budget.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && !atLast) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cache_line_mem_master.sv
// Cache-side initiator: optional writeback then optional refill on the line
// controller, one strobe per transfer, with a watchdog against lost ACKs.
module cache_line_mem_master
   import cache_mem_pkg::*;
#(
   parameter int SRAM_AW     = 18,
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 7
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   cache_line_mem_master_if.master bus
);

   mem_master_state_e state_q, state_d;

   logic              accept;
   logic              wdClear;
   logic              wdEnable;
   logic              timeout;
   logic              doRf_q;
   logic [31:0]       rfSramAddr_q;
   logic [31:0]       memAddr_q;
   logic [LINE_W-1:0] memWdata_q;
   logic              memWren_q;
   logic              memRden_q;
   logic              respValid_q;
   logic [LINE_W-1:0] respData_q;
   logic              err_q;
   logic              waiting;

   assign accept  = bus.i_req_valid && (state_q == IDLE);
   assign waiting = (state_q == WB_WAIT) || (state_q == RF_WAIT);

   mem_ack_watchdog #(
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .CNT_W      (CNT_W)
   ) u_watchdog (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (wdClear),
      .enable_i (wdEnable),
      .timeout_o(timeout)
   );

   // ACK is checked before the timeout so a same-cycle ACK still completes cleanly.
   always_comb begin
      state_d  = state_q;
      wdClear  = 1'b0;
      wdEnable = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.i_req_valid) begin
               if (bus.i_req_wb)      state_d = WB_REQ;
               else if (bus.i_req_rf) state_d = RF_REQ;
               else                   state_d = DONE;
            end
         end
         WB_REQ: begin
            wdClear = 1'b1;
            state_d = WB_WAIT;
         end
         WB_WAIT: begin
            wdEnable = 1'b1;
            if (bus.i_MEM_ACK)  state_d = doRf_q ? RF_REQ : DONE;
            else if (timeout)   state_d = DONE;
         end
         RF_REQ: begin
            wdClear = 1'b1;
            state_d = RF_WAIT;
         end
         RF_WAIT: begin
            wdEnable = 1'b1;
            if (bus.i_MEM_ACK || timeout) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobes follow the REQ states; address and write data only move at accept
   // or on the writeback-to-refill handover, so they stay put through each ACK.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         doRf_q       <= 1'b0;
         rfSramAddr_q <= '0;
         memAddr_q    <= '0;
         memWdata_q   <= '0;
         memWren_q    <= 1'b0;
         memRden_q    <= 1'b0;
         respValid_q  <= 1'b0;
         respData_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         memWren_q   <= (state_d == WB_REQ);
         memRden_q   <= (state_d == RF_REQ);
         respValid_q <= (state_q == DONE);
         if (accept) begin
            err_q        <= 1'b0;
            doRf_q       <= bus.i_req_rf;
            rfSramAddr_q <= line_to_sram_addr(bus.i_rf_addr, SRAM_AW);
            if (bus.i_req_wb) begin
               memAddr_q  <= line_to_sram_addr(bus.i_wb_addr, SRAM_AW);
               memWdata_q <= bus.i_wb_data;
            end else if (bus.i_req_rf) begin
               memAddr_q  <= line_to_sram_addr(bus.i_rf_addr, SRAM_AW);
            end
         end
         if ((state_q == WB_WAIT) && (state_d == RF_REQ)) begin
            memAddr_q <= rfSramAddr_q;
         end
         if ((state_q == RF_WAIT) && bus.i_MEM_ACK) begin
            respData_q <= bus.i_MEM_RDATA;
         end
         if (waiting && !bus.i_MEM_ACK && timeout) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.o_req_ready  = (state_q == IDLE);
   assign bus.o_resp_valid = respValid_q;
   assign bus.o_resp_data  = respData_q;
   assign bus.o_resp_err   = err_q;
   assign bus.o_MEM_ADDR   = memAddr_q;
   assign bus.o_MEM_WDATA  = memWdata_q;
   assign bus.o_MEM_WREN   = memWren_q;
   assign bus.o_MEM_RDEN   = memRden_q;

endmodule

// File: tb/tb_cache_line_mem_master.sv
// Randomized self-checking bench: a cycle-timeline model of each command
// predicts strobes, address windows, response timing, error and data.
module tb_cache_line_mem_master;
   import cache_mem_pkg::*;

   localparam int SRAM_AW = 18;
   localparam int TIMEOUT = 64;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   int   total  = 0;
   int   bad    = 0;
   logic [127:0] lastData = '0;

   always #5 clk_i = ~clk_i;

   cache_line_mem_master_if bus();

   cache_line_mem_master #(
      .SRAM_AW    (SRAM_AW),
      .TIMEOUT_CYC(TIMEOUT),
      .CNT_W      (7)
   ) dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (bus.master)
   );

   function automatic logic [31:0] expSram(input logic [31:0] a);
      longint unsigned lineIdx;
      lineIdx = (longint'(a) / 16) % (longint'(1) << (SRAM_AW - 3));
      return 32'(lineIdx * 8);
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkIdleZero(input string tag);
      checkOutput({tag, "_ready"}, 128'(bus.o_req_ready), 128'd1);
      checkOutput({tag, "_wren"},  128'(bus.o_MEM_WREN), 128'd0);
      checkOutput({tag, "_rden"},  128'(bus.o_MEM_RDEN), 128'd0);
      checkOutput({tag, "_addr"},  128'(bus.o_MEM_ADDR), 128'd0);
      checkOutput({tag, "_wdata"}, bus.o_MEM_WDATA, 128'd0);
      checkOutput({tag, "_rvalid"}, 128'(bus.o_resp_valid), 128'd0);
      checkOutput({tag, "_rerr"},  128'(bus.o_resp_err), 128'd0);
      checkOutput({tag, "_rdata"}, bus.o_resp_data, 128'd0);
   endtask

   // Delay d means ACK d cycles after the strobe; 0 or beyond the budget means no ACK.
   task automatic applyStimulus(input bit wb, input bit rf, input logic [31:0] wbAddr,
                                input logic [127:0] wbData, input logic [31:0] rfAddr,
                                input int wbDelay, input int rfDelay,
                                input logic [127:0] rdata, input bit spurious);
      int wbStrobe = -1, wbEnd = -1, wbAck = -1;
      int rfStrobe = -1, rfEnd = -1, rfAck = -1;
      int t = 0;
      int respCycle;
      bit expErr = 1'b0;
      bit ackNow;
      if (wb) begin
         wbStrobe = 1;
         if (wbDelay > 0 && wbDelay <= TIMEOUT) begin
            wbAck = wbStrobe + wbDelay;
            wbEnd = wbAck;
         end else begin
            wbEnd  = wbStrobe + TIMEOUT;
            expErr = 1'b1;
         end
         t = wbEnd;
      end
      if (rf && !expErr) begin
         rfStrobe = t + 1;
         if (rfDelay > 0 && rfDelay <= TIMEOUT) begin
            rfAck = rfStrobe + rfDelay;
            rfEnd = rfAck;
         end else begin
            rfEnd  = rfStrobe + TIMEOUT;
            expErr = 1'b1;
         end
         t = rfEnd;
      end
      respCycle = t + 2;
      for (int c = 0; c <= respCycle; c++) begin
         @(negedge clk_i);
         checkOutput("ready", 128'(bus.o_req_ready), 128'(c == 0 || c == respCycle));
         checkOutput("wren", 128'(bus.o_MEM_WREN), 128'(c == wbStrobe));
         checkOutput("rden", 128'(bus.o_MEM_RDEN), 128'(c == rfStrobe));
         checkOutput("resp_valid", 128'(bus.o_resp_valid), 128'(c == respCycle));
         if (wb && c >= wbStrobe && c <= wbEnd) begin
            checkOutput("wb_addr", 128'(bus.o_MEM_ADDR), 128'(expSram(wbAddr)));
            checkOutput("wb_wdata", bus.o_MEM_WDATA, wbData);
         end
         if (rfStrobe >= 0 && c >= rfStrobe && c <= rfEnd) begin
            checkOutput("rf_addr", 128'(bus.o_MEM_ADDR), 128'(expSram(rfAddr)));
         end
         if (c == respCycle) begin
            if (rfAck >= 0) lastData = rdata;
            checkOutput("resp_err", 128'(bus.o_resp_err), 128'(expErr));
            checkOutput("resp_data", bus.o_resp_data, lastData);
         end
         bus.i_req_valid = (c == 0);
         bus.i_req_wb    = (c == 0) ? wb : 1'($urandom);
         bus.i_req_rf    = (c == 0) ? rf : 1'($urandom);
         bus.i_wb_addr   = (c == 0) ? wbAddr : $urandom;
         bus.i_wb_data   = (c == 0) ? wbData : rand128();
         bus.i_rf_addr   = (c == 0) ? rfAddr : $urandom;
         ackNow = (c == wbAck) || (c == rfAck);
         if (spurious && (c == 0 || c == wbStrobe || c == rfStrobe || c == t + 1))
            ackNow = 1'b1;
         bus.i_MEM_ACK   = ackNow;
         bus.i_MEM_RDATA = (c == rfAck) ? rdata : rand128();
      end
   endtask

   function automatic int randDelay();
      int sel;
      sel = int'($urandom_range(0, 19));
      if (sel == 0) return 0;
      if (sel == 1) return TIMEOUT;
      if (sel == 2) return TIMEOUT - 1;
      return int'($urandom_range(1, 12));
   endfunction

   initial begin
      bus.i_req_valid = 1'b0;
      bus.i_req_wb    = 1'b0;
      bus.i_req_rf    = 1'b0;
      bus.i_wb_addr   = '0;
      bus.i_wb_data   = '0;
      bus.i_rf_addr   = '0;
      bus.i_MEM_RDATA = '0;
      bus.i_MEM_ACK   = 1'b0;
      #12;
      checkIdleZero("reset");
      @(negedge clk_i);
      rst_ni = 1'b1;

      applyStimulus(1'b0, 1'b1, 32'h0, '0, 32'h0000_0120, 0, 8,
                    128'h0123456789ABCDEF0123456789ABCDEF, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h40, {8{16'hAAAA}}, 32'h80, 5, 3, rand128(), 1'b0);
      applyStimulus(1'b0, 1'b0, $urandom, rand128(), $urandom, 0, 0, rand128(), 1'b0);
      applyStimulus(1'b0, 1'b1, 32'h0, '0, 32'h0000_0200, 0, 0, rand128(), 1'b0);
      applyStimulus(1'b0, 1'b1, 32'h0, '0, 32'h0000_0210, 0, 4, rand128(), 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h1000, rand128(), 32'h2000, 0, 2, rand128(), 1'b0);
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF0, rand128(), 32'h8765_4321, TIMEOUT, TIMEOUT,
                    rand128(), 1'b1);

      for (int n = 0; n < 40; n++) begin
         applyStimulus(1'($urandom), 1'($urandom), $urandom, rand128(), $urandom,
                       randDelay(), randDelay(), rand128(), 1'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk_i);
      end

      @(negedge clk_i);
      bus.i_req_valid = 1'b1;
      bus.i_req_wb    = 1'b0;
      bus.i_req_rf    = 1'b1;
      bus.i_rf_addr   = 32'h0000_0300;
      @(negedge clk_i);
      bus.i_req_valid = 1'b0;
      repeat (5) @(negedge clk_i);
      #1 rst_ni = 1'b0;
      #1 checkIdleZero("midrst");
      @(negedge clk_i);
      rst_ni   = 1'b1;
      lastData = '0;
      @(negedge clk_i);
      bus.i_MEM_ACK   = 1'b1;
      bus.i_MEM_RDATA = rand128();
      @(negedge clk_i);
      bus.i_MEM_ACK = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_i);
         checkOutput("postrst_rvalid", 128'(bus.o_resp_valid), 128'd0);
         checkOutput("postrst_ready", 128'(bus.o_req_ready), 128'd1);
         checkOutput("postrst_rden", 128'(bus.o_MEM_RDEN), 128'd0);
         checkOutput("postrst_addr", 128'(bus.o_MEM_ADDR), 128'd0);
      end
      applyStimulus(1'b0, 1'b1, 32'h0, '0, 32'h0000_0440, 0, 6, rand128(), 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
